// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//   Packet-level round-robin arbiter that merges NUM_IN AXI-Stream requesters
//   onto one mesh injection endpoint. A requester keeps the grant from its
//   first accepted beat until its tlast beat is accepted, so packets from
//   different sources never interleave. The merged stream leaves through a
//   2-entry buffer, so upstream ready comes from registers only.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   s_axis_*[NUM_IN]      per-requester AXI-Stream slave inputs (tvalid/tready
//                         are one bit per requester, payloads are arrays)
//   m_axis_*              merged AXI-Stream master output
//   grant_idx             current or most recently granted requester
//   busy                  1 while a multi-beat packet holds the grant
module axis_packet_arbiter #(
   parameter int NUM_IN      = 4,
   parameter int TDATA_WIDTH = 512,
   parameter int TUSER_WIDTH = 32,
   parameter int TID_WIDTH   = 2,
   parameter int TDEST_WIDTH = 4,
   parameter int TAG_SOURCE  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_IN-1:0]          s_axis_tvalid,
   output logic [NUM_IN-1:0]          s_axis_tready,
   input  logic [TDATA_WIDTH-1:0]     s_axis_tdata [NUM_IN],
   input  logic [NUM_IN-1:0]          s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0]     s_axis_tuser [NUM_IN],
   input  logic [TID_WIDTH-1:0]       s_axis_tid   [NUM_IN],
   input  logic [TDEST_WIDTH-1:0]     s_axis_tdest [NUM_IN],
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic [TID_WIDTH-1:0]       m_axis_tid,
   output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
   output logic [$clog2(NUM_IN)-1:0]  grant_idx,
   output logic                       busy
);

   localparam int IW = $clog2(NUM_IN);
   localparam logic [IW:0] NUM_IN_W = (IW+1)'(NUM_IN);

   generate
      if (NUM_IN < 2) begin : g_bad_num_in
         $error("axis_packet_arbiter: NUM_IN must be >= 2");
      end
      if (TAG_SOURCE != 0 && TID_WIDTH < IW) begin : g_bad_tid_width
         $error("axis_packet_arbiter: TID_WIDTH too narrow to carry the source index");
      end
   endgenerate

   typedef enum logic {IDLE, LOCKED} state_t;

   typedef struct packed {
      logic [TDATA_WIDTH-1:0] data;
      logic                   last;
      logic [TUSER_WIDTH-1:0] user;
      logic [TID_WIDTH-1:0]   id;
      logic [TDEST_WIDTH-1:0] dest;
   } beat_t;

   state_t        state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] grant_q, grant_d;

   beat_t         buf_mem [2];
   logic [1:0]    count_q;
   logic          wr_ptr_q, rd_ptr_q;

   logic          accept_ok, push, pop, found;
   logic [IW-1:0] sel, src;
   logic [IW:0]   cand;
   beat_t         in_beat, out_beat;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == IW'(NUM_IN-1)) ? '0 : i + 1'b1;
   endfunction

   // Upstream may push whenever the buffer is not full; taken from count_q
   // alone so no path runs from m_axis_tready to s_axis_tready.
   assign accept_ok = (count_q != 2'd2);
   assign pop       = m_axis_tvalid && m_axis_tready;

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand >= NUM_IN_W) cand = cand - NUM_IN_W;
         if (!found && s_axis_tvalid[cand[IW-1:0]]) begin
            found = 1'b1;
            sel   = cand[IW-1:0];
         end
      end
   end

   assign src = (state_q == LOCKED) ? grant_q : sel;

   always_comb begin
      s_axis_tready = '0;
      if (!rst && accept_ok && (state_q == LOCKED || found)) s_axis_tready[src] = 1'b1;
   end

   assign push = s_axis_tvalid[src] && s_axis_tready[src];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      if (push) begin
         grant_d = src;
         if (s_axis_tlast[src]) begin
            state_d  = IDLE;
            rr_ptr_d = next_idx(src);
         end else begin
            state_d  = LOCKED;
         end
      end
   end

   always_comb begin
      in_beat.data = s_axis_tdata[src];
      in_beat.last = s_axis_tlast[src];
      in_beat.user = s_axis_tuser[src];
      in_beat.id   = (TAG_SOURCE != 0) ? TID_WIDTH'(src) : s_axis_tid[src];
      in_beat.dest = s_axis_tdest[src];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: buffer storage is not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) buf_mem[wr_ptr_q] <= in_beat;
   end

   assign out_beat      = buf_mem[rd_ptr_q];
   assign m_axis_tvalid = (count_q != 2'd0);
   assign m_axis_tdata  = out_beat.data;
   assign m_axis_tlast  = out_beat.last;
   assign m_axis_tuser  = out_beat.user;
   assign m_axis_tid    = out_beat.id;
   assign m_axis_tdest  = out_beat.dest;
   assign grant_idx     = grant_q;
   assign busy          = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter
//   Drives two arbiter instances (TAG_SOURCE=1 and TAG_SOURCE=0) from the same
//   requester stimulus. A reference model tracks grant ownership, the
//   round-robin pointer and buffer occupancy from the arbitration rules and
//   queues every beat it expects to leave; an independent monitor pops that
//   queue whenever a DUT output handshake happens.
module tb_axis_packet_arbiter;

   localparam int N   = 4;
   localparam int DW  = 512;
   localparam int UW  = 32;
   localparam int IDW = 2;
   localparam int DSW = 4;
   localparam int IW  = 2;

   typedef struct {
      logic [DW-1:0]  data;
      logic           last;
      logic [UW-1:0]  user;
      logic [IDW-1:0] id;
      logic [DSW-1:0] dest;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]   s_tvalid, s_tlast, s_tready_a, s_tready_b;
   logic [DW-1:0]  s_tdata [N];
   logic [UW-1:0]  s_tuser [N];
   logic [IDW-1:0] s_tid   [N];
   logic [DSW-1:0] s_tdest [N];
   logic           m_tready;

   logic           ma_tvalid, ma_tlast, mb_tvalid, mb_tlast;
   logic [DW-1:0]  ma_tdata, mb_tdata;
   logic [UW-1:0]  ma_tuser, mb_tuser;
   logic [IDW-1:0] ma_tid, mb_tid;
   logic [DSW-1:0] ma_tdest, mb_tdest;
   logic [IW-1:0]  grant_a, grant_b;
   logic           busy_a, busy_b;

   axis_packet_arbiter #(.NUM_IN(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .TID_WIDTH(IDW), .TDEST_WIDTH(DSW), .TAG_SOURCE(1)) dut_a (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest),
      .m_axis_tvalid(ma_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(ma_tdata),
      .m_axis_tlast(ma_tlast), .m_axis_tuser(ma_tuser), .m_axis_tid(ma_tid),
      .m_axis_tdest(ma_tdest), .grant_idx(grant_a), .busy(busy_a));

   axis_packet_arbiter #(.NUM_IN(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW),
      .TID_WIDTH(IDW), .TDEST_WIDTH(DSW), .TAG_SOURCE(0)) dut_b (
      .clk(clk), .rst(rst),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_b), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest),
      .m_axis_tvalid(mb_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(mb_tdata),
      .m_axis_tlast(mb_tlast), .m_axis_tuser(mb_tuser), .m_axis_tid(mb_tid),
      .m_axis_tdest(mb_tdest), .grant_idx(grant_b), .busy(busy_b));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   bit    model_on = 1'b0;
   int    m_cnt, m_grant, m_rr;
   bit    m_locked;
   beat_t exp_a[$], exp_b[$];
   logic [IW-1:0] out_src[$];
   int    exp_src[$];

   task automatic model_step();
      int src;
      logic [IW-1:0] si;
      logic [N-1:0] want_rdy;
      bit acc, pop;
      beat_t ea, eb;
      if (rst) begin
         check("tready_during_reset_a", s_tready_a, '0);
         check("tready_during_reset_b", s_tready_b, '0);
         m_cnt = 0; m_locked = 0; m_grant = 0; m_rr = 0;
         exp_a.delete(); exp_b.delete();
         return;
      end
      check("m_tvalid_a", ma_tvalid, m_cnt > 0);
      check("m_tvalid_b", mb_tvalid, m_cnt > 0);
      check("busy", busy_a, m_locked);
      check("grant_idx", grant_a, m_grant);
      src = -1;
      if (m_locked) src = m_grant;
      else
         for (int k = 0; k < N; k++) begin
            si = IW'((m_rr + k) % N);
            if (src < 0 && s_tvalid[si]) src = int'(si);
         end
      want_rdy = '0;
      if (m_cnt < 2 && src >= 0) want_rdy[IW'(src)] = 1'b1;
      check("s_tready_a", s_tready_a, want_rdy);
      check("s_tready_b", s_tready_b, want_rdy);
      acc = (src >= 0) && want_rdy[IW'(src)] && s_tvalid[IW'(src)];
      pop = (m_cnt > 0) && m_tready;
      if (acc) begin
         si = IW'(src);
         ea.data = s_tdata[si]; ea.last = s_tlast[si]; ea.user = s_tuser[si];
         ea.dest = s_tdest[si]; ea.id = IDW'(src);
         eb = ea; eb.id = s_tid[si];
         exp_a.push_back(ea); exp_b.push_back(eb);
         m_grant = src;
         if (s_tlast[si]) begin m_locked = 0; m_rr = (src + 1) % N; end
         else m_locked = 1;
      end
      m_cnt = m_cnt + int'(acc) - int'(pop);
   endtask

   initial forever begin
      @(negedge clk);
      if (model_on) model_step();
   end

   // ---------------- output monitor ----------------
   initial forever begin
      beat_t e;
      @(negedge clk);
      if (model_on && !rst && m_tready) begin
         if (ma_tvalid) begin
            if (exp_a.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat_a: got tid %0d expected no beat", ma_tid);
            end else begin
               e = exp_a.pop_front();
               check("a_tdata", ma_tdata, e.data);
               check("a_tlast", ma_tlast, e.last);
               check("a_tuser", ma_tuser, e.user);
               check("a_tid",   ma_tid,   e.id);
               check("a_tdest", ma_tdest, e.dest);
               out_src.push_back(ma_tid);
            end
         end
         if (mb_tvalid) begin
            if (exp_b.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_beat_b: got tid %0d expected no beat", mb_tid);
            end else begin
               e = exp_b.pop_front();
               check("b_tdata", mb_tdata, e.data);
               check("b_tlast", mb_tlast, e.last);
               check("b_tid",   mb_tid,   e.id);
            end
         end
      end
   end

   // ---------------- requester drivers ----------------
   int npk[N], plen[N], beat[N], dly[N], gap_at[N], gap_n[N], fixlen[N];
   bit rnd = 1'b0, rnd_m = 1'b0;
   logic [N-1:0] acc_s;

   task automatic new_beat(input int i);
      for (int w = 0; w < DW/32; w++) s_tdata[i][w*32 +: 32] = $urandom;
      s_tuser[i] = $urandom;
      s_tid[i]   = IDW'($urandom);
      s_tdest[i] = DSW'($urandom);
      s_tlast[i] = (beat[i] == plen[i] - 1);
   endtask

   task automatic new_packet(input int i);
      plen[i] = (fixlen[i] > 0) ? fixlen[i] : int'($urandom_range(1, 4));
      beat[i] = 0;
      new_beat(i);
   endtask

   task automatic setup(input int i, input int n, input int len, input int d,
                        input int ga, input int gn);
      npk[i] = n; fixlen[i] = len; dly[i] = d; gap_at[i] = ga; gap_n[i] = gn;
      new_packet(i);
      s_tvalid[i] = (d == 0) && (n > 0);
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < N; i++) begin
         npk[i] = 0; dly[i] = 0; gap_n[i] = 0; fixlen[i] = 1; beat[i] = 0; plen[i] = 1;
      end
      s_tvalid = '0;
      s_tlast  = '0;
   endtask

   task automatic drive_update();
      bit v, pend;
      for (int i = 0; i < N; i++) begin
         pend = s_tvalid[i] && !acc_s[i];
         if (acc_s[i]) begin
            beat[i]++;
            if (beat[i] == plen[i]) begin npk[i]--; new_packet(i); end
            else new_beat(i);
         end
         if (dly[i] > 0) begin dly[i]--; v = 1'b0; end
         else if (npk[i] == 0) v = 1'b0;
         else if (gap_n[i] > 0 && beat[i] == gap_at[i]) begin gap_n[i]--; v = 1'b0; end
         else if (rnd && !pend) v = ($urandom_range(0, 3) != 0);
         else v = 1'b1;
         s_tvalid[i] = v;
      end
      if (rnd_m) m_tready = ($urandom_range(0, 2) != 0);
   endtask

   task automatic step();
      @(negedge clk);
      acc_s = s_tvalid & s_tready_a;
      @(posedge clk);
      #1;
      drive_update();
   endtask

   function automatic bit inputs_pending();
      for (int i = 0; i < N; i++) if (npk[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input string name, input int budget);
      int c = 0;
      while ((inputs_pending() || exp_a.size() != 0 || m_cnt != 0) && c < budget) begin
         step();
         c++;
      end
      if (c >= budget) begin
         total++; bad++;
         $display("FAIL %s_timeout: got %0d cycles expected drain within %0d", name, c, budget);
      end
   endtask

   task automatic check_order(input string name);
      check($sformatf("%s_beats", name), out_src.size(), exp_src.size());
      for (int k = 0; k < out_src.size() && k < exp_src.size(); k++)
         check($sformatf("%s_src%0d", name, k), out_src[k], exp_src[k]);
      out_src.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; m_tready = 1'b0; acc_s = '0;
      clear_inputs();
      for (int i = 0; i < N; i++) begin
         s_tdata[i] = '0; s_tuser[i] = '0; s_tid[i] = '0; s_tdest[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_on = 1'b1;

      // 1: all four requesters stream single-beat packets
      m_tready = 1'b1;
      for (int i = 0; i < N; i++) setup(i, 6, 1, 0, 0, 0);
      drain("rr_single", 200);
      exp_src.delete();
      for (int k = 0; k < 24; k++) exp_src.push_back(k % N);
      check_order("rr_single");

      // 2: 5-beat packet from input 1 while input 2 waits
      setup(1, 1, 5, 0, 0, 0);
      setup(2, 1, 1, 0, 0, 0);
      drain("locked_5beat", 100);
      exp_src = '{1, 1, 1, 1, 1, 2};
      check_order("locked_5beat");

      // 3: input 0 drops tvalid for 3 cycles mid-packet, input 3 waiting
      setup(0, 1, 4, 0, 2, 3);
      setup(3, 1, 1, 1, 0, 0);
      drain("tvalid_gap", 100);
      exp_src = '{0, 0, 0, 0, 3};
      check_order("tvalid_gap");

      // 4: downstream stall for 4 cycles mid-stream
      setup(1, 1, 8, 0, 0, 0);
      repeat (3) step();
      m_tready = 1'b0;
      repeat (4) step();
      check("stall_s_tready", s_tready_a, '0);
      m_tready = 1'b1;
      drain("stall", 100);
      exp_src = '{1, 1, 1, 1, 1, 1, 1, 1};
      check_order("stall");

      // 5: reset during the 3rd beat of a packet, then arbitration restarts at 0
      setup(2, 1, 5, 0, 0, 0);
      repeat (2) step();
      rst = 1'b1;
      m_tready = 1'b0;
      step();
      rst = 1'b0;
      clear_inputs();
      check("post_reset_m_tvalid", ma_tvalid, 1'b0);
      check("post_reset_busy", busy_a, 1'b0);
      check("post_reset_grant", grant_a, '0);
      m_tready = 1'b1;
      out_src.delete();
      setup(3, 1, 1, 0, 0, 0);
      setup(1, 1, 1, 0, 0, 0);
      drain("post_reset", 100);
      exp_src = '{1, 3};
      check_order("post_reset");

      // 6: move rr_ptr to 3, then inputs 3 and 0 compete (wrap-around)
      setup(2, 1, 1, 0, 0, 0);
      drain("wrap_pre", 50);
      setup(3, 1, 1, 0, 0, 0);
      setup(0, 1, 1, 0, 0, 0);
      drain("wrap", 50);
      exp_src = '{2, 3, 0};
      check_order("wrap");

      // 7: random packet lengths, random tvalid gaps, random backpressure
      rnd = 1'b1; rnd_m = 1'b1;
      for (int i = 0; i < N; i++) setup(i, 15, 0, int'($urandom_range(0, 3)), 0, 0);
      drain("random", 3000);
      rnd = 1'b0; rnd_m = 1'b0; m_tready = 1'b1;
      out_src.delete();
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-level round-robin arbiter that shares one mesh injection endpoint (a single AXI-Stream tile input) among NUM_IN local requesters.
- Once granted, a requester holds the grant until its tlast beat is accepted. Packets from different sources are therefore never interleaved at the shim_in serializer.
- Output is registered through a 2-entry skid buffer, so no ready/valid path is combinational from input to output.

Parameters:
- NUM_IN, 4, number of requesters; must be >= 2.
- TDATA_WIDTH, 512, data width.
- TUSER_WIDTH, 32, user sideband width.
- TID_WIDTH, 2, id width.
- TDEST_WIDTH, 4, mesh destination width.
- TAG_SOURCE, 1, if 1 then m_axis_tid carries the granted input index. Requires TID_WIDTH >= $clog2(NUM_IN); elaboration error otherwise.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1 [NUM_IN]  per-requester valid.
- s_axis_tready  out  1 [NUM_IN]  per-requester ready.
- s_axis_tdata  in  TDATA_WIDTH [NUM_IN]  per-requester data.
- s_axis_tlast  in  1 [NUM_IN]  per-requester end of packet.
- s_axis_tuser  in  TUSER_WIDTH [NUM_IN]  per-requester user sideband.
- s_axis_tid  in  TID_WIDTH [NUM_IN]  per-requester id; ignored when TAG_SOURCE=1.
- s_axis_tdest  in  TDEST_WIDTH [NUM_IN]  per-requester mesh destination.
- m_axis_tvalid  out  1  merged stream valid, toward the tile axis_in port.
- m_axis_tready  in  1  merged stream ready.
- m_axis_tdata / tlast / tuser / tid / tdest  out  as above  merged stream payload.
- grant_idx  out  $clog2(NUM_IN)  current or last granted input.
- busy  out  1  1 while in LOCKED state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0.
  - Skid buffer emptied; m_axis_tvalid=0.
  - All s_axis_tready=0 during the reset cycle.
  - An in-flight packet is discarded; no partial-packet recovery.
- Skid buffer (2 entries):
  - space = (count < 2) registered as (count==0) || (count==1 && !pop-blocked). Equivalently, upstream-facing accept_ok = !full, taken from registers only.
  - push on a granted-input handshake; pop on m_axis_tvalid && m_axis_tready.
  - Simultaneous push and pop at count 1 or 2 keeps count unchanged.
  - Order is preserved. Throughput is 1 beat/cycle when m_axis_tready is held at 1.
- Latency: an input beat accepted in cycle N appears on m_axis_* in cycle N+1 at the earliest.
- State IDLE:
  - Combinationally select the first i with s_axis_tvalid[i]=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ...).
  - If a requester is found and accept_ok=1, assert s_axis_tready[sel] in the same cycle and accept the beat.
  - If that beat has tlast=1: stay IDLE and set rr_ptr = (sel+1) mod NUM_IN.
  - Otherwise: go to LOCKED with grant=sel.
  - grant_idx updates to sel on acceptance.
  - With no valid requester, or accept_ok=0, nothing changes.
- State LOCKED:
  - s_axis_tready[grant] = accept_ok; all other readys are 0.
  - On an accepted beat with tlast=1: go to IDLE and set rr_ptr = (grant+1) mod NUM_IN.
  - Deassertion of tvalid by the granted requester mid-packet does not release the grant; other requesters wait.
- Back-to-back single-beat packets from different requesters are accepted on consecutive cycles, with no bubble.
- s_axis_tready is never 1 for a non-granted input. s_axis_tready never depends combinationally on m_axis_tready.
- Output fields: tdata, tlast, tuser and tdest are copied unchanged. tid = TAG_SOURCE ? zero-extended source index : s_axis_tid.
- rr_ptr wraps from NUM_IN-1 to 0.
- Starvation bound: a requester waits at most NUM_IN-1 packets.

Test Plan:
- Reset, then all four inputs present 1-beat packets (tlast=1) continuously with m_axis_tready=1 -> output sources 0,1,2,3,0,1 on consecutive cycles; m_axis_tid equals the source; first m_axis_tvalid one cycle after the first accept.
- Input 1 sends a 5-beat packet while input 2 is valid throughout -> all 5 input-1 beats are contiguous on output; s_axis_tready[2]=0 until after input 1's tlast; busy=1 for the duration.
- Input 0 drops tvalid for 3 cycles mid-packet while input 3 is valid -> no input-3 beat is accepted; the grant stays at 0 until input 0's tlast.
- m_axis_tready=0 for 4 cycles during a stream -> exactly 2 beats are buffered, s_axis_tready falls to 0, no beat is lost or duplicated, and order is preserved on release.
- rst asserted in the middle of the 3rd beat of a packet -> next cycle m_axis_tvalid=0, busy=0, grant_idx=0; afterwards arbitration restarts from input 0.
- rr_ptr=3 with only inputs 3 and 0 valid -> order is 3 then 0 (wrap-around); TAG_SOURCE=0 run -> m_axis_tid passes s_axis_tid unchanged.
